// File: rtl/subleq_pkg.sv
// Shared types and I/O address helpers for the SUBLEQ core.
package subleq_pkg;

  typedef enum logic [2:0] {
    FETCH_A,
    FETCH_B,
    FETCH_C,
    READ_A,
    READ_B,
    WRITE,
    HALT
  } state_t;

  // The top three addresses of the space are the memory-mapped ports.
  function automatic int unsigned io_in_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd3;
  endfunction

  function automatic int unsigned io_out_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd2;
  endfunction

  function automatic int unsigned io_halt_addr(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

endpackage

// File: rtl/subleq_exec.sv
// SUBLEQ datapath: wrapped subtract mem[B]-mem[A] and signed <=0 branch flag.
module subleq_exec #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] va,
  input  logic [DATA_W-1:0] vb,
  output logic [DATA_W-1:0] result_c,
  output logic              le_c
);

  assign result_c = vb - va;
  assign le_c     = result_c[DATA_W-1] | (result_c == '0);

endmodule

// File: rtl/subleq_core.sv
// SUBLEQ CPU core with req/ack memory port and valid/ready stream I/O.
// Optional `SUBLEQ_STEP_EN adds a step input for single-instruction debug.
module subleq_core
  import subleq_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
`ifdef SUBLEQ_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] IN_ADDR   = ADDR_W'(io_in_addr(ADDR_W));
  localparam logic [ADDR_W-1:0] OUT_ADDR  = ADDR_W'(io_out_addr(ADDR_W));
  localparam logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(io_halt_addr(ADDR_W));

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic [ADDR_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DATA_W-1:0] va_q, va_d, vb_q, vb_d;
  logic [DATA_W-1:0] result_c;
  logic              le_c, start_c, wr_done_c;
  logic [ADDR_W-1:0] target_c;

`ifdef SUBLEQ_STEP_EN
  assign start_c = ena & step;
`else
  assign start_c = ena;
`endif

  subleq_exec #(.DATA_W(DATA_W)) u_exec (
    .va       (va_q),
    .vb       (vb_q),
    .result_c (result_c),
    .le_c     (le_c)
  );

  assign target_c  = le_c ? c_q : ADDR_W'(pc_q + ADDR_W'(3));
  assign wr_done_c = (b_q == OUT_ADDR) ? out_ready :
                     ((b_q >= IN_ADDR) ? 1'b1 : mem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_A;
      run_q   <= 1'b0;
      pc_q    <= ADDR_W'(RESET_PC);
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      va_q    <= '0;
      vb_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
    end
  end

  // run_q marks an issued instruction; ena is only looked at while it is clear.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    va_d    = va_q;
    vb_d    = vb_q;
    unique case (state_q)
      FETCH_A: begin
        if (!run_q) begin
          if (start_c) run_d = 1'b1;
        end else if (mem_ack) begin
          a_d     = ADDR_W'(mem_rdata);
          state_d = FETCH_B;
        end
      end
      FETCH_B: if (mem_ack) begin
        b_d     = ADDR_W'(mem_rdata);
        state_d = FETCH_C;
      end
      FETCH_C: if (mem_ack) begin
        c_d     = ADDR_W'(mem_rdata);
        state_d = READ_A;
      end
      READ_A: begin
        if (a_q == IN_ADDR) begin
          if (in_valid) begin
            va_d    = in_data;
            state_d = READ_B;
          end
        end else if (a_q > IN_ADDR) begin
          va_d    = '0;
          state_d = READ_B;
        end else if (mem_ack) begin
          va_d    = mem_rdata;
          state_d = READ_B;
        end
      end
      READ_B: begin
        if (b_q == IN_ADDR) begin
          if (in_valid) begin
            vb_d    = in_data;
            state_d = WRITE;
          end
        end else if (b_q > IN_ADDR) begin
          vb_d    = '0;
          state_d = WRITE;
        end else if (mem_ack) begin
          vb_d    = mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE: if (wr_done_c) begin
        run_d   = 1'b0;
        pc_d    = target_c;
        state_d = (target_c == HALT_ADDR) ? HALT : FETCH_A;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH_A;
    endcase
  end

  // Outputs decode registered state only, so mem_ack may close the loop combinationally.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    unique case (state_q)
      FETCH_A: if (run_q) begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      FETCH_B: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'(pc_q + ADDR_W'(1));
      end
      FETCH_C: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_W'(pc_q + ADDR_W'(2));
      end
      READ_A: begin
        if (a_q == IN_ADDR) begin
          in_ready = 1'b1;
        end else if (a_q < IN_ADDR) begin
          mem_req  = 1'b1;
          mem_addr = a_q;
        end
      end
      READ_B: begin
        if (b_q == IN_ADDR) begin
          in_ready = 1'b1;
        end else if (b_q < IN_ADDR) begin
          mem_req  = 1'b1;
          mem_addr = b_q;
        end
      end
      WRITE: begin
        if (b_q == OUT_ADDR) begin
          out_valid = 1'b1;
          out_data  = result_c;
        end else if (b_q < IN_ADDR) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = b_q;
          mem_wdata = result_c;
        end
      end
      default: ;
    endcase
  end

  assign halted = (state_q == HALT);
  assign pc     = pc_q;

endmodule

// File: tb/tb_subleq_core.sv
// Self-checking bench for subleq_core: directed vectors, I/O and reset corners, random programs vs a model.
module tb_subleq_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
`ifdef SUBLEQ_STEP_EN
  logic       step = 1'b1;
`endif
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0] in_data, out_data, pc;
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, halted;

  subleq_core #(.DATA_W(8), .ADDR_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
`ifdef SUBLEQ_STEP_EN
    .step(step),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  // Memory with programmable ack delay, reloaded from prog while in reset; stream bookkeeping.
  logic [7:0] mem [256];
  logic [7:0] prog [256];
  logic [7:0] in_words [64];
  logic [7:0] out_got [$];
  int         in_idx, cnt, dly = 0, acc_cnt = 0;
  logic       stale_ack = 1'b0;
  logic       auto_io = 1'b0, man_iv = 1'b0, man_or = 1'b0;

  assign mem_ack   = (mem_req && (cnt >= dly)) || stale_ack;
  assign mem_rdata = mem[mem_addr];
  assign in_data   = in_words[in_idx[5:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 0;
      in_idx <= 0;
      out_got.delete();
      for (int i = 0; i < 256; i++) mem[i] = prog[i];
    end else begin
      if (mem_req && mem_ack) begin
        acc_cnt++;
        cnt <= 0;
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else if (mem_req) cnt <= cnt + 1;
      else cnt <= 0;
      if (in_valid && in_ready) in_idx <= in_idx + 1;
      if (out_valid && out_ready) out_got.push_back(out_data);
    end
  end

  always @(negedge clk) begin
    in_valid  = auto_io ? ($urandom_range(0, 2) != 0) : man_iv;
    out_ready = auto_io ? ($urandom_range(0, 2) != 0) : man_or;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ena   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start one instruction, drop ena once it is issued, wait until the core idles again.
  task automatic run_instr(output int acc);
    int n, idle, st;
    ena = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 40) begin @(negedge clk); n++; end
    ena = 1'b0;
    if (n >= 40) tmo("instr_start");
    st = acc_cnt;
    idle = 0;
    n = 0;
    while (idle < 4 && n < 400) begin
      @(negedge clk);
      n++;
      idle = (!mem_req && !in_ready && !out_valid) ? idle + 1 : 0;
    end
    if (n >= 400) tmo("instr_done");
    acc = acc_cnt - st;
  endtask

  // Reference model: instruction-level SUBLEQ semantics.
  logic [7:0] mm [256];
  logic [7:0] mpc;
  logic [7:0] mout [$];
  int         mi;
  bit         mh;

  function automatic logic [7:0] mread(input logic [7:0] ad);
    if (ad == 8'd253) begin
      mi++;
      return in_words[mi-1];
    end
    if (ad > 8'd253) return 8'd0;
    return mm[ad];
  endfunction

  task automatic model_step();
    logic [7:0] a, b, c, va, vb, r;
    a  = mm[mpc];
    b  = mm[8'(mpc + 8'd1)];
    c  = mm[8'(mpc + 8'd2)];
    va = mread(a);
    vb = mread(b);
    r  = 8'(vb - va);
    if (b == 8'd254) mout.push_back(r);
    else if (b < 8'd253) mm[b] = r;
    mpc = ($signed(r) <= 0) ? c : 8'(mpc + 8'd3);
    if (mpc == 8'd255) mh = 1'b1;
  endtask

  typedef struct {
    logic [7:0] va, vb, c;
    int         d;
    logic [7:0] exp_b, exp_pc;
    int         exp_acc;
  } vec_t;
  vec_t tab [6];

  initial begin
    int acc, n, k, diffs;
    for (int i = 0; i < 256; i++) prog[i] = 8'd0;
    for (int i = 0; i < 64; i++) in_words[i] = 8'd0;

    // reset values, and ena low keeps the core quiet
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 0);
    chk("rst_we_addr", {23'd0, mem_we, mem_addr}, 0);
    chk("rst_wdata", {24'd0, mem_wdata}, 0);
    chk("rst_io", {21'd0, in_ready, out_valid, halted, out_data}, 0);
    chk("rst_pc", {24'd0, pc}, 0);
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin @(negedge clk); if (mem_req) n++; end
    chk("ena_low_hold", n, 0);

    tab[0] = '{8'h05, 8'h03, 8'd3,  0, 8'hFE, 8'd3,  6};
    tab[1] = '{8'h01, 8'h05, 8'd9,  1, 8'h04, 8'd3,  6};
    tab[2] = '{8'h80, 8'h7F, 8'd40, 2, 8'hFF, 8'd40, 6};
    tab[3] = '{8'h03, 8'h03, 8'd100, 3, 8'h00, 8'd100, 6};
    tab[4] = '{8'h7F, 8'h80, 8'd50, 0, 8'h01, 8'd3,  6};
    tab[5] = '{8'h01, 8'h80, 8'd77, 1, 8'h7F, 8'd3,  6};
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) prog[i] = 8'd0;
      prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = tab[t].c;
      prog[10] = tab[t].va; prog[11] = tab[t].vb;
      dly = tab[t].d;
      do_reset();
      run_instr(acc);
      chk($sformatf("vec%0d_memB", t), {24'd0, mem[11]}, {24'd0, tab[t].exp_b});
      chk($sformatf("vec%0d_pc", t), {24'd0, pc}, {24'd0, tab[t].exp_pc});
      chk($sformatf("vec%0d_acc", t), acc, tab[t].exp_acc);
      n = 0;
      repeat (8) begin @(negedge clk); if (mem_req || pc != tab[t].exp_pc) n++; end
      chk($sformatf("vec%0d_stall", t), n, 0);
    end

    // pc 254 falling through wraps to 1
    for (int i = 0; i < 256; i++) prog[i] = 8'd0;
    prog[0] = 8'd20; prog[1] = 8'd20; prog[2] = 8'd254; prog[20] = 8'd9;
    prog[254] = 8'd10; prog[255] = 8'd11; prog[10] = 8'd1; prog[11] = 8'd5;
    dly = 1;
    do_reset();
    run_instr(acc);
    chk("wrap_pc254", {24'd0, pc}, 254);
    run_instr(acc);
    chk("wrap_pc1", {24'd0, pc}, 1);
    chk("wrap_memB", {24'd0, mem[11]}, 4);
    chk("wrap_nohalt", {31'd0, halted}, 0);

    // pc+3 landing on HALT halts
    for (int i = 0; i < 256; i++) prog[i] = 8'd0;
    prog[0] = 8'd20; prog[1] = 8'd20; prog[2] = 8'd252;
    prog[252] = 8'd10; prog[253] = 8'd11; prog[10] = 8'd1; prog[11] = 8'd5;
    dly = 0;
    do_reset();
    run_instr(acc);
    run_instr(acc);
    chk("fall_halt", {31'd0, halted}, 1);
    chk("fall_halt_pc", {24'd0, pc}, 255);
    ena = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (mem_req || in_ready || out_valid) n++; end
    ena = 1'b0;
    chk("halt_quiet", n, 0);

    // stream I/O: late in_valid, output stalled 4 cycles, then halt
    for (int i = 0; i < 256; i++) prog[i] = 8'd0;
    prog[0] = 8'd253; prog[1] = 8'd12;  prog[2] = 8'd3;
    prog[3] = 8'd12;  prog[4] = 8'd254; prog[5] = 8'd200;
    prog[6] = 8'd13;  prog[7] = 8'd13;  prog[8] = 8'd255;
    in_words[0] = 8'h07;
    auto_io = 1'b0; man_iv = 1'b0; man_or = 1'b0; dly = 1;
    do_reset();
    ena = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    ena = 1'b0;
    if (n >= 50) tmo("io_in_ready");
    k = 0;
    repeat (5) begin @(negedge clk); if (in_ready) k++; end
    chk("io_in_wait", k, 5);
    man_iv = 1'b1;
    n = 0;
    while (in_ready && n < 20) begin @(negedge clk); n++; end
    man_iv = 1'b0;
    n = 0;
    while (pc != 8'd3 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) tmo("io_pc3");
    chk("io_in_count", in_idx, 1);
    chk("io_sub", {24'd0, mem[12]}, 32'hF9);
    ena = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    ena = 1'b0;
    if (n >= 50) tmo("io_out_valid");
    k = 0;
    repeat (4) begin @(negedge clk); if (out_valid && out_data == 8'h07) k++; end
    chk("io_out_hold", k, 4);
    man_or = 1'b1;
    n = 0;
    while (out_valid && n < 20) begin @(negedge clk); n++; end
    man_or = 1'b0;
    chk("io_out_cnt", out_got.size(), 1);
    if (out_got.size() > 0) chk("io_out_data", {24'd0, out_got[0]}, 32'h07);
    chk("io_pc6", {24'd0, pc}, 6);
    run_instr(acc);
    chk("io_halted", {31'd0, halted}, 1);
    chk("io_halt_pc", {24'd0, pc}, 255);

    // reset while READ_B is waiting on ack; a stale ack afterwards is ignored
    for (int i = 0; i < 256; i++) prog[i] = 8'd0;
    prog[0] = 8'd10; prog[1] = 8'd11; prog[2] = 8'd3; prog[10] = 8'd5; prog[11] = 8'd3;
    dly = 3;
    do_reset();
    ena = 1'b1;
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 8'd11) && n < 60) begin @(negedge clk); n++; end
    ena = 1'b0;
    if (n >= 60) tmo("rb_reach");
    rst_n = 1'b0;
    #1;
    chk("rb_rst_req", {23'd0, mem_req, mem_addr}, 0);
    chk("rb_rst_pc", {24'd0, pc}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale_ack = 1'b1;
    repeat (2) @(negedge clk);
    stale_ack = 1'b0;
    chk("rb_idle", {23'd0, mem_req, pc}, 0);
    run_instr(acc);
    chk("rb_memB", {24'd0, mem[11]}, 32'hFE);
    chk("rb_pc", {24'd0, pc}, 3);
    chk("rb_acc", acc, 6);

    // random programs in instruction lockstep with the model
    auto_io = 1'b1;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) begin
        k = int'($urandom_range(0, 11));
        prog[i] = (k == 0) ? 8'd253 : (k == 1) ? 8'd254 : 8'($urandom_range(0, 255));
      end
      for (int i = 0; i < 64; i++) in_words[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) mm[i] = prog[i];
      mpc = 8'd0; mi = 0; mh = 1'b0;
      mout.delete();
      dly = int'($urandom_range(0, 3));
      do_reset();
      for (int s = 0; s < 20 && !mh; s++) begin
        run_instr(acc);
        model_step();
        chk($sformatf("rnd%0d_%0d_pc", p, s), {24'd0, pc}, {24'd0, mpc});
        chk($sformatf("rnd%0d_%0d_halt", p, s), {31'd0, halted}, {31'd0, mh});
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) diffs++;
        chk($sformatf("rnd%0d_%0d_mem", p, s), diffs, 0);
        chk($sformatf("rnd%0d_%0d_nout", p, s), out_got.size(), mout.size());
        diffs = 0;
        for (int i = 0; i < mout.size() && i < out_got.size(); i++)
          if (out_got[i] !== mout[i]) diffs++;
        chk($sformatf("rnd%0d_%0d_out", p, s), diffs, 0);
      end
    end
    auto_io = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
